// File: rtl/hm_pkg.sv
// Shared types for the nonce-sweep engine.
//   HASH_W     : width of a SHA-256 digest / difficulty target
//   hash_t     : 256-bit digest type
//   hm_state_t : engine control states
package hm_pkg;

  localparam int unsigned HASH_W = 256;

  typedef logic [HASH_W-1:0] hash_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } hm_state_t;

endpackage

// File: rtl/hm_round_counter.sv
// Compression-round counter for one SHA pass.
//   clk, n_rst : clock, async active-low reset
//   clear      : force count to 0
//   cnt_up     : advance one round
//   count      : current round index (0..ROUNDS-1)
//   rollover   : last round of the pass is being counted this cycle
module hm_round_counter #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      cnt_up,
  output logic [$clog2(ROUNDS)-1:0] count,
  output logic                      rollover
);

  localparam int unsigned CW = $clog2(ROUNDS);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign rollover = cnt_up && (count_q == CW'(ROUNDS - 1));
  assign count    = count_q;

  // Next count: clear has priority, wrap to 0 after the last round.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (cnt_up) begin
      count_d = rollover ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hm_nonce_engine.sv
// Autonomous nonce-sweep engine sequencing one external SHA-256 core.
//   begin_hash/quit_hash           : start pulse / abort request
//   nonce_start/nonce_count/difficulty : sweep range and target, sampled on start
//   out_hash                       : core result, valid in CHECK
//   sha_clear/sha_halt/hash_select : core sequencing (load, freeze, pass index)
//   cur_nonce, busy                : nonce under test, sweep in progress
//   hash_done/search_done          : per-nonce / end-of-sweep pulses
//   valid_hash_flag/valid_hash/valid_nonce : held winning result
module hm_nonce_engine
  import hm_pkg::*;
#(
  parameter int unsigned MODULE_NUM   = 0,
  parameter int unsigned NONCE_STRIDE = 1,
  parameter int unsigned ROUNDS       = 64,
  parameter int unsigned PASSES       = 3,
  parameter int unsigned NONCE_W      = 32
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               begin_hash,
  input  logic               quit_hash,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_count,
  input  hash_t              difficulty,
  input  hash_t              out_hash,
  output logic               sha_clear,
  output logic               sha_halt,
  output logic [1:0]         hash_select,
  output logic [NONCE_W-1:0] cur_nonce,
  output logic               busy,
  output logic               hash_done,
  output logic               search_done,
  output logic               valid_hash_flag,
  output hash_t              valid_hash,
  output logic [NONCE_W-1:0] valid_nonce
);

  localparam int unsigned CW = $clog2(ROUNDS);

  hm_state_t          state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] remain_q, remain_d;
  hash_t              diff_q, diff_d;
  logic [1:0]         pass_q, pass_d;
  logic               vflag_q, vflag_d;
  hash_t              vhash_q, vhash_d;
  logic [NONCE_W-1:0] vnonce_q, vnonce_d;
  logic               clear_q, clear_d;
  logic               halt_q, halt_d;
  logic               busy_q, busy_d;
  logic               hdone_q, hdone_d;
  logic               sdone_q, sdone_d;

  logic               rollover;
  logic [CW-1:0]      round_cnt_unused;

  // Round counter is cleared while the core loads and counts while it runs.
  hm_round_counter #(
    .ROUNDS (ROUNDS)
  ) u_round_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (state_q == CLEAR),
    .cnt_up   (state_q == RUN),
    .count    (round_cnt_unused),
    .rollover (rollover)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    nonce_d  = nonce_q;
    remain_d = remain_q;
    diff_d   = diff_q;
    pass_d   = pass_q;
    vflag_d  = vflag_q;
    vhash_d  = vhash_q;
    vnonce_d = vnonce_q;

    case (state_q)
      IDLE: begin
        if (begin_hash && !quit_hash) begin
          vflag_d  = 1'b0;
          vhash_d  = '0;
          vnonce_d = '0;
          diff_d   = difficulty;
          if (nonce_count != '0) begin
            nonce_d  = nonce_start + NONCE_W'(MODULE_NUM);
            remain_d = nonce_count;
            pass_d   = 2'd0;
            state_d  = CLEAR;
          end else begin
            state_d  = DONE;
          end
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (rollover) begin
          if (pass_q != 2'(PASSES - 1)) begin
            pass_d  = pass_q + 2'd1;
            state_d = CLEAR;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (out_hash < diff_q) begin
          vflag_d  = 1'b1;
          vhash_d  = out_hash;
          vnonce_d = nonce_q;
          state_d  = DONE;
        end else if (remain_q == NONCE_W'(1)) begin
          state_d  = DONE;
        end else begin
          nonce_d  = nonce_q + NONCE_W'(NONCE_STRIDE);
          remain_d = remain_q - NONCE_W'(1);
          pass_d   = 2'd0;
          state_d  = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a winner found this cycle.
    if (quit_hash && (state_q != IDLE)) begin
      state_d  = IDLE;
      vflag_d  = vflag_q;
      vhash_d  = vhash_q;
      vnonce_d = vnonce_q;
    end

    // Outputs are registered, so decode them from the state being entered.
    clear_d = (state_d == CLEAR);
    halt_d  = (state_d != RUN);
    busy_d  = (state_d != IDLE);
    hdone_d = (state_d == CHECK);
    sdone_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      nonce_q  <= '0;
      remain_q <= '0;
      diff_q   <= '0;
      pass_q   <= '0;
      vflag_q  <= 1'b0;
      vhash_q  <= '0;
      vnonce_q <= '0;
      clear_q  <= 1'b0;
      halt_q   <= 1'b1;
      busy_q   <= 1'b0;
      hdone_q  <= 1'b0;
      sdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      nonce_q  <= nonce_d;
      remain_q <= remain_d;
      diff_q   <= diff_d;
      pass_q   <= pass_d;
      vflag_q  <= vflag_d;
      vhash_q  <= vhash_d;
      vnonce_q <= vnonce_d;
      clear_q  <= clear_d;
      halt_q   <= halt_d;
      busy_q   <= busy_d;
      hdone_q  <= hdone_d;
      sdone_q  <= sdone_d;
    end
  end

  assign sha_clear       = clear_q;
  assign sha_halt        = halt_q;
  assign hash_select     = pass_q;
  assign cur_nonce       = nonce_q;
  assign busy            = busy_q;
  assign hash_done       = hdone_q;
  assign search_done     = sdone_q;
  assign valid_hash_flag = vflag_q;
  assign valid_hash      = vhash_q;
  assign valid_nonce     = vnonce_q;

endmodule

// File: tb/tb_hm_nonce_engine.sv
// Bench for hm_nonce_engine: three instances (default, offset/stride, 8-bit
// nonce) share stimulus; a mode selects which one is being checked.
module tb_hm_nonce_engine;
  import hm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        begin_hash, quit_hash;
  logic [31:0] nonce_start, nonce_count;
  hash_t       difficulty;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-parameter instance
  logic d0_clear, d0_halt, d0_busy, d0_hd, d0_sd, d0_vf;
  logic [1:0]  d0_sel;
  logic [31:0] d0_nonce, d0_vn;
  hash_t       d0_vh, d0_oh;
  assign d0_oh = 256'(d0_nonce) ^ 256'h25;

  hm_nonce_engine u_dut0 (
    .clk(clk), .n_rst(n_rst), .begin_hash(begin_hash), .quit_hash(quit_hash),
    .nonce_start(nonce_start), .nonce_count(nonce_count), .difficulty(difficulty),
    .out_hash(d0_oh), .sha_clear(d0_clear), .sha_halt(d0_halt), .hash_select(d0_sel),
    .cur_nonce(d0_nonce), .busy(d0_busy), .hash_done(d0_hd), .search_done(d0_sd),
    .valid_hash_flag(d0_vf), .valid_hash(d0_vh), .valid_nonce(d0_vn)
  );

  // Offset 1, stride 4 instance
  logic d1_clear, d1_halt, d1_busy, d1_hd, d1_sd, d1_vf;
  logic [1:0]  d1_sel;
  logic [31:0] d1_nonce, d1_vn;
  hash_t       d1_vh, d1_oh;
  assign d1_oh = 256'(d1_nonce) ^ 256'h25;

  hm_nonce_engine #(.MODULE_NUM(1), .NONCE_STRIDE(4)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .begin_hash(begin_hash), .quit_hash(quit_hash),
    .nonce_start(nonce_start), .nonce_count(nonce_count), .difficulty(difficulty),
    .out_hash(d1_oh), .sha_clear(d1_clear), .sha_halt(d1_halt), .hash_select(d1_sel),
    .cur_nonce(d1_nonce), .busy(d1_busy), .hash_done(d1_hd), .search_done(d1_sd),
    .valid_hash_flag(d1_vf), .valid_hash(d1_vh), .valid_nonce(d1_vn)
  );

  // 8-bit nonce instance
  logic d2_clear, d2_halt, d2_busy, d2_hd, d2_sd, d2_vf;
  logic [1:0] d2_sel;
  logic [7:0] d2_nonce, d2_vn;
  hash_t      d2_vh, d2_oh;
  assign d2_oh = 256'(d2_nonce) ^ 256'h25;

  hm_nonce_engine #(.NONCE_W(8)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .begin_hash(begin_hash), .quit_hash(quit_hash),
    .nonce_start(nonce_start[7:0]), .nonce_count(nonce_count[7:0]), .difficulty(difficulty),
    .out_hash(d2_oh), .sha_clear(d2_clear), .sha_halt(d2_halt), .hash_select(d2_sel),
    .cur_nonce(d2_nonce), .busy(d2_busy), .hash_done(d2_hd), .search_done(d2_sd),
    .valid_hash_flag(d2_vf), .valid_hash(d2_vh), .valid_nonce(d2_vn)
  );

  // Selected instance view
  int          mode = 0;
  logic        s_hd, s_sd, s_vf;
  logic [31:0] s_nonce, s_vn;
  hash_t       s_vh;
  always_comb begin
    case (mode)
      1: begin
        s_hd = d1_hd; s_sd = d1_sd; s_vf = d1_vf;
        s_nonce = d1_nonce; s_vn = d1_vn; s_vh = d1_vh;
      end
      2: begin
        s_hd = d2_hd; s_sd = d2_sd; s_vf = d2_vf;
        s_nonce = {24'd0, d2_nonce}; s_vn = {24'd0, d2_vn}; s_vh = d2_vh;
      end
      default: begin
        s_hd = d0_hd; s_sd = d0_sd; s_vf = d0_vf;
        s_nonce = d0_nonce; s_vn = d0_vn; s_vh = d0_vh;
      end
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected nonces pushed at start, popped on each hash_done.
  logic [31:0] exp_q[$];
  int hd_cnt = 0;
  int sd_cnt = 0;
  int first_hd_cyc = -1;

  always @(negedge clk) begin
    if (n_rst) begin
      if (s_hd) begin
        hd_cnt++;
        if (first_hd_cyc < 0) first_hd_cyc = cyc + 1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_hash_done: nonce %0h with nothing expected", s_nonce);
        end else begin
          check("hd_nonce", 256'(s_nonce), 256'(exp_q.pop_front()));
        end
      end
      if (s_sd) sd_cnt++;
    end
  end

  int k;

  task automatic quiesce();
    @(negedge clk);
    quit_hash = 1'b1;
    @(negedge clk);
    quit_hash = 1'b0;
  endtask

  // Pulse begin_hash; k is the edge that samples it. Returns in cycle k+1.
  task automatic start(input logic [31:0] st, input logic [31:0] cnt, input hash_t df);
    nonce_start  = st;
    nonce_count  = cnt;
    difficulty   = df;
    first_hd_cyc = -1;
    begin_hash   = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    begin_hash = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cyc + 1 < c) @(negedge clk);
  endtask

  typedef struct {
    int          md;
    logic [31:0] st;
    logic [31:0] cnt;
    hash_t       df;
    logic        found;
    logic [31:0] e_nonce;
    hash_t       e_hash;
    int          dones;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int hd0, sd0, lat, off, strd;
    logic got;
    logic [31:0] n;

    vecs[0] = '{0, 32'h20,  32'd16, 256'd3, 1'b1, 32'h24, 256'h01, 5, 981};
    vecs[1] = '{0, 32'h20,  32'd4,  256'd0, 1'b0, 32'h0,  256'h0,  4, 785};
    vecs[2] = '{0, 32'h25,  32'd2,  256'd1, 1'b1, 32'h25, 256'h0,  1, 197};
    vecs[3] = '{0, 32'h40,  32'd0,  256'd3, 1'b0, 32'h0,  256'h0,  0, 1};
    vecs[4] = '{0, 32'h20,  32'd1,  256'd5, 1'b0, 32'h0,  256'h0,  1, 197};
    vecs[5] = '{1, 32'h20,  32'd4,  256'd3, 1'b1, 32'h25, 256'h0,  2, 393};
    vecs[6] = '{2, 32'hFE,  32'd3,  256'd0, 1'b0, 32'h0,  256'h0,  3, 589};
    vecs[7] = '{0, 32'h20,  32'd1,  256'd6, 1'b1, 32'h20, 256'h05, 1, 197};

    n_rst = 1'b0;
    begin_hash = 1'b0;
    quit_hash = 1'b0;
    nonce_start = '0;
    nonce_count = '0;
    difficulty = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_halt",   256'(d0_halt),  256'd1);
    check("rst_busy",   256'(d0_busy),  256'd0);
    check("rst_clear",  256'(d0_clear), 256'd0);
    check("rst_sel",    256'(d0_sel),   256'd0);
    check("rst_nonce",  256'(d0_nonce), 256'd0);
    check("rst_vflag",  256'(d0_vf),    256'd0);
    check("rst_vhash",  d0_vh,          256'd0);
    check("rst_pulses", 256'({d0_hd, d0_sd}), 256'd0);
    n_rst = 1'b1;

    // Table-driven sweeps
    foreach (vecs[i]) begin
      quiesce();
      mode = vecs[i].md;
      exp_q.delete();
      off  = (vecs[i].md == 1) ? 1 : 0;
      strd = (vecs[i].md == 1) ? 4 : 1;
      for (int j = 0; j < vecs[i].dones; j++) begin
        n = vecs[i].st + 32'(off) + 32'(j * strd);
        if (vecs[i].md == 2) n = n & 32'hFF;
        exp_q.push_back(n);
      end
      hd0 = hd_cnt;
      start(vecs[i].st, vecs[i].cnt, vecs[i].df);
      got = 1'b0;
      lat = -1;
      for (int t = 0; t < 3000; t++) begin
        if (s_sd) begin
          got = 1'b1;
          lat = cyc + 1 - k;
          break;
        end
        @(negedge clk);
      end
      check($sformatf("v%0d_done_seen", i), 256'(got), 256'd1);
      check($sformatf("v%0d_done_lat", i), 256'(lat), 256'(vecs[i].lat));
      check($sformatf("v%0d_vflag", i), 256'(s_vf), 256'(vecs[i].found));
      check($sformatf("v%0d_vnonce", i), 256'(s_vn), 256'(vecs[i].e_nonce));
      check($sformatf("v%0d_vhash", i), s_vh, vecs[i].e_hash);
      check($sformatf("v%0d_hd_count", i), 256'(hd_cnt - hd0), 256'(vecs[i].dones));
      check($sformatf("v%0d_sb_empty", i), 256'(exp_q.size()), 256'd0);
      if (vecs[i].dones > 0)
        check($sformatf("v%0d_first_hd_lat", i), 256'(first_hd_cyc - k), 256'd196);
    end

    // Abort mid-RUN, with an ignored begin_hash while busy
    quiesce();
    mode = 0;
    exp_q.delete();
    sd0 = sd_cnt;
    hd0 = hd_cnt;
    start(32'h20, 32'd16, 256'd0);
    check("q_clear_k1", 256'({d0_clear, d0_halt, d0_busy}), 256'b111);
    check("q_nonce_k1", 256'(d0_nonce), 256'h20);
    @(negedge clk);
    check("q_run_k2", 256'({d0_clear, d0_halt, d0_sel}), 256'b0000);
    goto(k + 50);
    nonce_start = 32'h80;
    begin_hash = 1'b1;
    @(negedge clk);
    begin_hash = 1'b0;
    goto(k + 66);
    check("q_clear2_k66", 256'({d0_clear, d0_halt, d0_sel}), 256'b1101);
    check("q_busy_begin_ignored", 256'(d0_nonce), 256'h20);
    goto(k + 100);
    quit_hash = 1'b1;
    @(negedge clk);
    quit_hash = 1'b0;
    check("q_idle_k101", 256'({d0_busy, d0_halt, d0_clear}), 256'b010);
    repeat (4) @(negedge clk);
    check("q_no_search_done", 256'(sd_cnt - sd0), 256'd0);
    check("q_no_hash_done", 256'(hd_cnt - hd0), 256'd0);

    // Abort in a winning CHECK: no latch, no search_done
    quiesce();
    exp_q.delete();
    exp_q.push_back(32'h20);
    sd0 = sd_cnt;
    start(32'h20, 32'd1, {256{1'b1}});
    goto(k + 196);
    check("qc_in_check", 256'(d0_hd), 256'd1);
    quit_hash = 1'b1;
    @(negedge clk);
    quit_hash = 1'b0;
    check("qc_busy", 256'(d0_busy), 256'd0);
    check("qc_vflag", 256'(d0_vf), 256'd0);
    repeat (3) @(negedge clk);
    check("qc_no_search_done", 256'(sd_cnt - sd0), 256'd0);

    // Reset asserted mid-RUN
    quiesce();
    exp_q.delete();
    start(32'h20, 32'd16, 256'd0);
    goto(k + 70);
    check("r_running", 256'({d0_busy, d0_halt, d0_sel}), 256'b1001);
    n_rst = 1'b0;
    #1;
    check("r_outputs", 256'({d0_busy, d0_halt, d0_clear, d0_sel, d0_hd, d0_sd}), 256'b0100000);
    check("r_nonce", 256'(d0_nonce), 256'd0);
    @(negedge clk);
    n_rst = 1'b1;
    sd0 = sd_cnt;
    repeat (3) @(negedge clk);
    check("r_stays_idle", 256'({d0_busy, d0_halt}), 256'b01);
    check("r_no_search_done", 256'(sd_cnt - sd0), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
